// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Hazard and stall controller for the 5-stage MIPS pipeline.
//            Resolves load-use hazards in ID, jump/branch control hazards,
//            and multi-cycle MEM accesses with a not-ready watchdog.
// Options  : HAZARD_PERF_EN adds saturating stall_cycles / flush_count.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,  // legal range 2..255
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic       id_jump,
  input  logic [4:0] ex_rt,
  input  logic       ex_memread,
  input  logic       ex_branch_taken,
  input  logic       mem_req,
  input  logic       dmem_ready,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       exmem_en,
  output logic       memwb_bubble,
  output logic       mem_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam logic [7:0] c_timeout = 8'(MEM_TIMEOUT);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_wait_cnt;
  logic [7:0] w_wait_nxt;

  logic w_lu;
  logic w_ms;

  // RUN-rule outputs for the non-memory hazards, shared by RUN and the
  // MEM_WAIT completion cycle.
  logic w_run_pc_en;
  logic w_run_ifid_en;
  logic w_run_ifid_flush;
  logic w_run_idex_flush;

  assign w_lu = ex_memread && (ex_rt != 5'd0) &&
                ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign w_ms = mem_req && !dmem_ready;

  // Priority decode of branch > load-use > jump when memory is not stalling.
  always_comb begin
    w_run_pc_en      = 1'b1;
    w_run_ifid_en    = 1'b1;
    w_run_ifid_flush = 1'b0;
    w_run_idex_flush = 1'b0;
    if (ex_branch_taken) begin
      w_run_ifid_flush = 1'b1;
      w_run_idex_flush = 1'b1;
    end else if (w_lu) begin
      // one-cycle stall: the bubble in ID/EX clears ex_memread next cycle
      w_run_pc_en      = 1'b0;
      w_run_ifid_en    = 1'b0;
      w_run_idex_flush = 1'b1;
    end else if (id_jump) begin
      w_run_ifid_flush = 1'b1;
    end
  end

  // State register and consecutive-frozen-cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= RUN;
      r_wait_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  // Next-state, watchdog and Mealy output decode; reset overrides everything.
  always_comb begin
    w_state_nxt  = r_state;
    w_wait_nxt   = r_wait_cnt;
    pc_en        = w_run_pc_en;
    ifid_en      = w_run_ifid_en;
    ifid_flush   = w_run_ifid_flush;
    idex_flush   = w_run_idex_flush;
    exmem_en     = 1'b1;
    memwb_bubble = 1'b0;
    mem_err      = 1'b0;

    case (r_state)
      RUN: begin
        if (w_ms) begin
          pc_en        = 1'b0;
          ifid_en      = 1'b0;
          ifid_flush   = 1'b0;
          idex_flush   = 1'b0;
          exmem_en     = 1'b0;
          memwb_bubble = 1'b1;
          w_state_nxt  = MEM_WAIT;
          w_wait_nxt   = 8'd1;  // this cycle is the first frozen one
        end else begin
          w_wait_nxt   = 8'd0;
        end
      end
      MEM_WAIT: begin
        if (!dmem_ready) begin
          pc_en        = 1'b0;
          ifid_en      = 1'b0;
          ifid_flush   = 1'b0;
          idex_flush   = 1'b0;
          exmem_en     = 1'b0;
          memwb_bubble = 1'b1;
          if ((r_wait_cnt + 8'd1) >= c_timeout) begin
            w_state_nxt = ERR;
          end
          w_wait_nxt = r_wait_cnt + 8'd1;
        end else begin
          w_state_nxt = RUN;
          w_wait_nxt  = 8'd0;
        end
      end
      ERR: begin
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        exmem_en     = 1'b0;
        memwb_bubble = 1'b1;
        mem_err      = 1'b1;
      end
      default: begin
        w_state_nxt = RUN;
        w_wait_nxt  = 8'd0;
      end
    endcase

    if (rst) begin
      w_state_nxt  = RUN;
      w_wait_nxt   = 8'd0;
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      exmem_en     = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      memwb_bubble = 1'b1;
      mem_err      = 1'b0;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_count;

  // Saturating performance counters; ERR cycles are not counted as stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (!pc_en && (r_state != ERR) && (r_stall_cycles != {CNT_W{1'b1}})) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
      if ((ifid_flush || idex_flush) && (r_flush_count != {CNT_W{1'b1}})) begin
        r_flush_count <= r_flush_count + 1'b1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Self-checking bench for hazard_ctrl: vector table for the
//            single-cycle hazard decode plus hand-written multi-cycle
//            sequences (memory wait, watchdog, asynchronous reset).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int CNT_W = 32;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, id_jump, ex_memread, ex_branch_taken, mem_req, dmem_ready;
  logic       pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_bubble, mem_err;
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cycles, flush_count;
`endif

  hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .id_jump         (id_jump),
    .ex_rt           (ex_rt),
    .ex_memread      (ex_memread),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .dmem_ready      (dmem_ready),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .exmem_en        (exmem_en),
    .memwb_bubble    (memwb_bubble),
    .mem_err         (mem_err)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cycles    (stall_cycles),
    .flush_count     (flush_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector order: {pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_bubble, mem_err}
  localparam logic [6:0] c_norm = 7'b1100100;
  localparam logic [6:0] c_frz  = 7'b0000010;
  localparam logic [6:0] c_br   = 7'b1111100;
  localparam logic [6:0] c_lu   = 7'b0001100;
  localparam logic [6:0] c_jmp  = 7'b1110100;
  localparam logic [6:0] c_errv = 7'b0000011;
  localparam logic [6:0] c_rstv = 7'b0011010;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       jump;
    logic [4:0] ex_rt;
    logic       memread;
    logic       br;
    logic       mreq;
    logic       rdy;
  } in_t;

  typedef struct {
    in_t        in;
    logic [6:0] exp;
    string      name;
  } vec_t;

  typedef struct {
    logic [6:0] exp;
    string      name;
  } sb_t;

  sb_t  sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tbl[14];

  function automatic in_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                             input logic jmp, input logic [4:0] xrt, input logic mr,
                             input logic br, input logic mq, input logic rd);
    in_t t;
    t.rs = rs; t.rt = rt; t.uses_rt = uses; t.jump = jmp; t.ex_rt = xrt;
    t.memread = mr; t.br = br; t.mreq = mq; t.rdy = rd;
    return t;
  endfunction

  task automatic drive(input in_t t);
    id_rs = t.rs; id_rt = t.rt; id_uses_rt = t.uses_rt; id_jump = t.jump;
    ex_rt = t.ex_rt; ex_memread = t.memread; ex_branch_taken = t.br;
    mem_req = t.mreq; dmem_ready = t.rdy;
  endtask

  task automatic chk_val(input logic [31:0] got, input logic [31:0] exp, input string name);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Pop the oldest expected record and compare it against the live outputs.
  task automatic sb_check();
    sb_t e;
    logic [6:0] got;
    if (sb_q.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_empty: got nothing expected an entry");
      return;
    end
    e   = sb_q.pop_front();
    got = {pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_bubble, mem_err};
    n_cmp++;
    if (got !== e.exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", e.name, got, e.exp);
    end
  endtask

  // Called at posedge+1: drive, sample at negedge, advance to next posedge+1.
  task automatic cycle(input in_t t, input logic [6:0] exp, input string name);
    sb_t e;
    drive(t);
    e.exp = exp; e.name = name;
    sb_q.push_back(e);
    @(negedge clk);
    sb_check();
    @(posedge clk);
    #1;
  endtask

  // Short asynchronous reset pulse between clock edges.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  in_t idle, mw, mr;

  initial begin
    sb_t e;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    mw   = mk(0, 0, 0, 0, 0, 0, 0, 1, 0);
    mr   = mk(0, 0, 0, 0, 0, 0, 0, 1, 1);

    tbl[0]  = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0), c_norm, "idle"};
    tbl[1]  = '{mk(8, 9, 1, 0, 8, 1, 0, 0, 0), c_lu,   "lu_rs"};
    tbl[2]  = '{mk(8, 9, 1, 0, 0, 0, 0, 0, 0), c_norm, "lu_released"};
    tbl[3]  = '{mk(3, 8, 1, 0, 8, 1, 0, 0, 0), c_lu,   "lu_rt"};
    tbl[4]  = '{mk(3, 8, 0, 0, 8, 1, 0, 0, 0), c_norm, "rt_unused"};
    tbl[5]  = '{mk(0, 0, 1, 0, 0, 1, 0, 0, 0), c_norm, "lu_r0"};
    tbl[6]  = '{mk(8, 0, 0, 0, 8, 0, 0, 0, 0), c_norm, "no_memread"};
    tbl[7]  = '{mk(8, 8, 1, 0, 8, 1, 1, 0, 0), c_br,   "br_over_lu"};
    tbl[8]  = '{mk(0, 0, 0, 1, 0, 0, 1, 0, 0), c_br,   "br_over_jump"};
    tbl[9]  = '{mk(0, 0, 0, 1, 0, 0, 0, 0, 0), c_jmp,  "jump"};
    tbl[10] = '{mk(0, 0, 0, 0, 0, 0, 0, 0, 0), c_norm, "jump_one_cycle"};
    tbl[11] = '{mk(8, 0, 0, 1, 8, 1, 0, 0, 0), c_lu,   "lu_over_jump"};
    tbl[12] = '{mk(0, 0, 0, 0, 0, 0, 0, 1, 1), c_norm, "mem_ready_first"};
    tbl[13] = '{mk(8, 0, 0, 0, 8, 1, 0, 1, 1), c_lu,   "mem_ready_lu"};

    rst = 1'b1;
    drive(idle);
    #2;
    e.exp = c_rstv; e.name = "reset_hold";
    sb_q.push_back(e);
    sb_check();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single-cycle hazard decode table
    for (int i = 0; i < 14; i++) begin
      cycle(tbl[i].in, tbl[i].exp, tbl[i].name);
    end

    // Memory wait: three not-ready cycles, then completion
    do_reset();
    cycle(mw,   c_frz,  "mw_frz0");
    cycle(mw,   c_frz,  "mw_frz1");
    cycle(mw,   c_frz,  "mw_frz2");
    cycle(mr,   c_norm, "mw_done");
    cycle(idle, c_norm, "mw_after");
`ifdef HAZARD_PERF_EN
    chk_val(stall_cycles, 32'd3, "mw_stall_cycles");
    chk_val(flush_count,  32'd0, "mw_flush_count");
`endif

    // Watchdog: ready stuck low from cycle 0
    do_reset();
    for (int i = 0; i < 15; i++) begin
      cycle(mw, c_frz, $sformatf("to_frz%0d", i));
    end
    cycle(mw,   c_errv, "to_err15");
    cycle(mr,   c_errv, "to_sticky_rdy");
    cycle(idle, c_errv, "to_sticky_idle");
`ifdef HAZARD_PERF_EN
    chk_val(stall_cycles, 32'd15, "to_stall_cycles");
`endif

    // Ready rises in cycle 14: no error, RUN in cycle 15
    do_reset();
    for (int i = 0; i < 14; i++) begin
      cycle(mw, c_frz, $sformatf("r14_frz%0d", i));
    end
    cycle(mr,   c_norm, "r14_ready");
    cycle(idle, c_norm, "r14_run15");

    // Asynchronous reset in MEM_WAIT, released before the next edge
    do_reset();
    cycle(mw, c_frz, "ar_enter");
    drive(mw);
    #1;
    rst = 1'b1;
    #1;
    e.exp = c_rstv; e.name = "ar_rst_out";
    sb_q.push_back(e);
    sb_check();
    #1;
    rst = 1'b0;
    cycle(idle, c_norm, "ar_run");
    cycle(mw,   c_frz,  "ar_frz_again");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the 5-stage MIPS core. It sits beside the main decoder and drives the pipeline-register enables and flushes. It resolves three hazards: load-use data hazards in ID, control hazards from jumps resolved in ID and branches resolved in EX, and multi-cycle data-memory accesses in MEM through a ready handshake with a timeout watchdog.

## Interface
Parameters:
- MEM_TIMEOUT, 15: consecutive not-ready MEM cycles tolerated before the error state; legal range 2..255.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  pipeline clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs  in  5  rs field of the instruction in ID.
- id_rt  in  5  rt field of the instruction in ID.
- id_uses_rt  in  1  the ID instruction reads rt (R-type, beq/bne, sw).
- id_jump  in  1  Jump decoded in ID.
- ex_rt  in  5  destination rt of the instruction in EX.
- ex_memread  in  1  MemRead of the instruction in EX.
- ex_branch_taken  in  1  branch in EX resolved taken.
- mem_req  in  1  MemRead or MemWrite of the instruction in MEM.
- dmem_ready  in  1  data memory completes the MEM access this cycle.
- pc_en  out  1  PC write enable.
- ifid_en  out  1  IF/ID write enable.
- ifid_flush  out  1  load a nop into IF/ID.
- idex_flush  out  1  load a bubble (all controls 0) into ID/EX.
- exmem_en  out  1  EX/MEM write enable.
- memwb_bubble  out  1  load a bubble into MEM/WB.
- mem_err  out  1  sticky watchdog error.
- stall_cycles  out  CNT_W  performance counter; exists only with the macro defined.
- flush_count  out  CNT_W  performance counter; exists only with the macro defined.

## Operation
- FSM states: RUN, MEM_WAIT, ERR. Reset state is RUN. Outputs are Mealy, decoded from the state and the current inputs.
- **Load-use hazard (lu):** lu = ex_memread && ex_rt != 0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt)).
- **Memory stall (ms):** ms = mem_req && !dmem_ready.
- **RUN, priority order:**
  1. ms: freeze. pc_en = ifid_en = exmem_en = 0, ifid_flush = idex_flush = 0, memwb_bubble = 1. Next state MEM_WAIT.
  2. ex_branch_taken: pc_en = ifid_en = exmem_en = 1, ifid_flush = idex_flush = 1. This overrides lu and id_jump.
  3. lu: pc_en = ifid_en = 0, idex_flush = 1, exmem_en = 1. The stall lasts one cycle because the bubble clears ex_memread.
  4. id_jump: all enables 1, ifid_flush = 1.
  5. Otherwise: all enables 1, all flushes and bubble 0.
- **MEM_WAIT:**
  - While dmem_ready = 0: same freeze outputs as RUN case 1.
  - In the cycle dmem_ready = 1: outputs follow the RUN rules for the current inputs; next state RUN.
- **Watchdog:** wait_cnt counts consecutive frozen cycles, including the RUN cycle that entered the wait. When dmem_ready is still 0 at the end of the MEM_TIMEOUT-th such cycle, next state is ERR. wait_cnt clears whenever the FSM is in RUN without ms.
- **ERR:** all enables 0, all flushes 0, memwb_bubble = 1, mem_err = 1. ERR is left only by reset.
- **While rst is high:** state RUN, wait_cnt = 0, pc_en = ifid_en = exmem_en = 0, ifid_flush = idex_flush = memwb_bubble = 1, mem_err = 0, counters 0.
- **Reset mid-stall:** FSM returns to RUN immediately. The first cycle after reset deassertion obeys the RUN rules.

## Timing
- Hazard outputs are combinational from the inputs in the same cycle; there is no added latency.
- A MEM access completing with ready on its first cycle costs 0 stall cycles. Each not-ready cycle adds exactly 1 stall cycle.
- With MEM_TIMEOUT = 15 and dmem_ready held low from cycle 0: frozen in cycles 0..14, mem_err = 1 from cycle 15.
- If dmem_ready rises in cycle 14, no error occurs and the FSM is in RUN in cycle 15.

## Configuration
- HAZARD_PERF_EN defined: stall_cycles and flush_count are present. Both are saturating, cleared by reset.
  - stall_cycles increments on every cycle with pc_en = 0 in RUN or MEM_WAIT (not while rst is high, not in ERR).
  - flush_count increments on every cycle with ifid_flush or idex_flush = 1 outside reset.
- HAZARD_PERF_EN undefined: both ports and their registers are absent. All other behaviour is identical.

## Test plan
- **Load-use:** lw into $8 in EX, add using $8 as rs in ID -> one cycle with pc_en = 0, ifid_en = 0, idex_flush = 1. Next cycle all enables are 1. With ex_rt = 0 -> no stall.
- **Branch over load-use:** ex_branch_taken = 1 with lu true -> ifid_flush = idex_flush = 1, pc_en = 1.
- **Jump:** id_jump = 1 alone -> ifid_flush = 1 for exactly one cycle; idex_flush = 0.
- **Memory wait:** mem_req = 1, dmem_ready low for 3 cycles -> 3 frozen cycles with memwb_bubble = 1, then advance. With HAZARD_PERF_EN, stall_cycles = 3.
- **Timeout:** MEM_TIMEOUT = 15, dmem_ready stuck low -> mem_err = 1 from cycle 15 and stays 1 after dmem_ready rises. Ready in cycle 14 -> mem_err stays 0.
- **Async reset:** assert rst between clock edges in MEM_WAIT -> outputs take their reset values immediately. After release, the FSM is in RUN and mem_err = 0.
